apb_master_arbiter: RTL and testbench

- Single APB master that shares the peripheral APB bus between two requesters: req0 (I2C command path) and req1 (host/debug path).
- Round-robin arbitration, then a standard SETUP/ACCESS transfer on the bus; the result is returned to the winning requester.
- Slaves drive pready as 1'bz when not selected, so a bounded wait-state timeout prevents bus lock on unmapped addresses.

---
 rtl/apb_master_pkg.sv | 19 +
 rtl/apb_rr_arbiter2.sv | 43 ++++
 rtl/apb_master_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_master_pkg;

  // Bus phase of the single APB master.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  // Requester indices: req0 is the I2C command path, req1 the host/debug path.
  localparam int unsigned Req0Idx = 0;
  localparam int unsigned Req1Idx = 1;
  localparam int unsigned NumReq  = 2;

  // ACCESS cycles allowed without pready before error-completion.
  localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered last-grant pointer.
module apb_rr_arbiter2
  import apb_master_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1: req1 won most recently, so req0 wins the next conflict.
  logic last_q, last_d;

  // Grant the lone requester, or on conflict the one not granted last.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Advance the pointer only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[Req1Idx];
    end
  end

  // Pointer register; reset value makes req0 win the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS transfer,
// wait-state timeout, and per-requester completion reporting.
module apb_master_arbiter
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 32,
  parameter int unsigned TIMEOUT           = DefaultTimeout
) (
  input  logic                         pclk,
  input  logic                         reset,

  input  logic                         req0_valid,
  input  logic                         req0_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req0_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req0_wdata,
  output logic                         req0_ack,
  output logic                         req0_done,
  output logic                         req0_err,
  output logic [DATA_BUS_WIDTH-1:0]    req0_rdata,

  input  logic                         req1_valid,
  input  logic                         req1_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req1_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req1_wdata,
  output logic                         req1_ack,
  output logic                         req1_done,
  output logic                         req1_err,
  output logic [DATA_BUS_WIDTH-1:0]    req1_rdata,

  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDRESS_BUS_WIDTH-1:0] paddr,
  output logic [DATA_BUS_WIDTH-1:0]    pwdata,
  input  logic [DATA_BUS_WIDTH-1:0]    prdata,
  input  logic                         pready
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  apb_state_e                   state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         idx_q, idx_d;
  logic [ADDRESS_BUS_WIDTH-1:0] paddr_q, paddr_d;
  logic                         pwrite_q, pwrite_d;
  logic [DATA_BUS_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [NumReq-1:0]            done_q, done_d;
  logic [NumReq-1:0]            err_q, err_d;
  logic [DATA_BUS_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [DATA_BUS_WIDTH-1:0]    rdata1_q, rdata1_d;

  logic [1:0]                   gnt;
  logic                         in_idle;
  logic                         pready_hit;
  logic [DATA_BUS_WIDTH-1:0]    resp_data;

  // Undriven slaves float pready; only a solid 1 completes the transfer.
  assign pready_hit = (pready === 1'b1);
  assign in_idle    = (state_q == StIdle);

  apb_rr_arbiter2 u_arb (
    .clk_i    (pclk),
    .rst_ni   (reset),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (in_idle),
    .gnt_o    (gnt)
  );

  // Next-state: arbitration in IDLE, fixed SETUP, ACCESS with wait/timeout handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    err_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    resp_data = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          state_d = StSetup;
          cnt_d   = '0;
          idx_d   = gnt[Req1Idx];
          if (gnt[Req1Idx]) begin
            paddr_d  = req1_addr;
            pwrite_d = req1_write;
            pwdata_d = req1_wdata;
          end else begin
            paddr_d  = req0_addr;
            pwrite_d = req0_write;
            pwdata_d = req0_wdata;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
      end

      StAccess: begin
        if (pready_hit) begin
          state_d       = StIdle;
          done_d[idx_q] = 1'b1;
          // Write completions report zero; prdata may be floating then.
          resp_data     = pwrite_q ? '0 : prdata;
        end else if (cnt_q == CntLast) begin
          state_d       = StIdle;
          done_d[idx_q] = 1'b1;
          err_d[idx_q]  = 1'b1;
          resp_data     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (done_d[idx_q]) begin
          if (idx_q) begin
            rdata1_d = resp_data;
          end else begin
            rdata0_d = resp_data;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, operand latches and response registers.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Acks are the IDLE-cycle grant; forced low while reset is held.
  assign req0_ack = reset & in_idle & gnt[Req0Idx];
  assign req1_ack = reset & in_idle & gnt[Req1Idx];

  // psel/penable decode straight from state so reset drops them immediately.
  assign psel    = (state_q != StIdle);
  assign penable = (state_q == StAccess);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

  assign req0_done  = done_q[Req0Idx];
  assign req1_done  = done_q[Req1Idx];
  assign req0_err   = err_q[Req0Idx];
  assign req1_err   = err_q[Req1Idx];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: stimulus pushes expected transfers,
// a negedge monitor checks bus phases and completions against the queue.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          pclk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  wire           pready;

  // Bench slave controls
  logic [DW-1:0] slave_rdata = '0;
  int            slave_waits = 0;
  logic          slave_z = 1'b0;
  logic          pready_drv;
  int            acc_run;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            idx;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] last_rd0, last_rd1;

  apb_master_arbiter #(
    .ADDRESS_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH    (DW),
    .TIMEOUT           (TO)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ack   (req0_ack),
    .req0_done  (req0_done),
    .req0_err   (req0_err),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ack   (req1_ack),
    .req1_done  (req1_done),
    .req1_err   (req1_err),
    .req1_rdata (req1_rdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready)
  );

  always #5 pclk = ~pclk;

  // Slave: counts ACCESS cycles of the current transfer and answers after slave_waits.
  always @(posedge pclk or negedge reset) begin
    if (!reset) begin
      acc_run <= 0;
    end else if (psel && !penable) begin
      acc_run <= 0;
    end else if (psel && penable) begin
      acc_run <= acc_run + 1;
    end
  end

  assign pready_drv = psel && penable && (acc_run == slave_waits);
  assign pready     = slave_z ? 1'bz : pready_drv;
  assign prdata     = slave_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rd,
                      input int acc);
    exp_t e;
    e.idx = idx; e.write = wr; e.addr = addr; e.wdata = wd;
    e.err = err; e.rdata = rd; e.acc = acc;
    sb.push_back(e);
  endtask

  // Raise a request, wait for its ack, check the ack is one cycle wide.
  task automatic issue(input int idx, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input bit keep);
    bit seen = 1'b0;
    @(posedge pclk); #1;
    if (idx == 0) begin
      req0_write = wr; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if ((idx == 0) ? req0_ack : req1_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("ack_seen_req%0d_addr%0h", idx, addr), 64'(seen), 64'd1);
    @(negedge pclk);
    chk($sformatf("ack_one_cycle_req%0d", idx), 64'((idx == 0) ? req0_ack : req1_ack), 64'd0);
    if (!keep) begin
      if (idx == 0) req0_valid = 1'b0;
      else          req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk);
      if (sb.size() == 0) break;
    end
    @(negedge pclk);
    chk("drain_queue", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: SETUP operands, ACCESS stability, and completion responses.
  always @(negedge pclk) begin
    if (!reset) begin
      last_rd0 = '0;
      last_rd1 = '0;
    end else begin
      if (psel && !penable) begin
        if (sb.size() == 0) begin
          chk("unexpected_setup", 64'd1, 64'd0);
        end else begin
          chk("setup_operands", {15'd0, paddr, pwrite, pwdata},
              {15'd0, sb[0].addr, sb[0].write, sb[0].wdata});
        end
      end
      if (psel && penable && sb.size() != 0) begin
        chk("access_stable", {15'd0, paddr, pwrite, pwdata},
            {15'd0, sb[0].addr, sb[0].write, sb[0].wdata});
      end
      if (req0_done || req1_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {62'd0, req1_done, req0_done}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_which", {62'd0, req1_done, req0_done}, (e.idx == 1) ? 64'd2 : 64'd1);
          chk("done_err", 64'((e.idx == 1) ? req1_err : req0_err), 64'(e.err));
          chk("done_rdata", 64'((e.idx == 1) ? req1_rdata : req0_rdata), 64'(e.rdata));
          chk("access_cycles", 64'(acc_run), 64'(e.acc));
          chk("idle_at_done", {62'd0, psel, penable}, 64'd0);
          if (e.idx == 1) begin
            chk("other_rdata_hold", 64'(req0_rdata), 64'(last_rd0));
            last_rd1 = e.rdata;
          end else begin
            chk("other_rdata_hold", 64'(req1_rdata), 64'(last_rd1));
            last_rd0 = e.rdata;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack1_seen;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_bus_ctrl", {61'd0, psel, penable, pwrite}, 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_acks_dones_errs",
        {58'd0, req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err}, 64'd0);
    chk("rst_rdatas", {req1_rdata, req0_rdata}, 64'd0);
    reset = 1'b1;

    // Read hit, zero wait
    slave_waits = 0;
    slave_rdata = 32'hAABB_CCDD;
    push(0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'hAABB_CCDD, 1);
    issue(0, 1'b0, 16'h0000, 32'h0, 1'b0);
    wait_idle();

    // Write with three wait states
    slave_waits = 3;
    push(1, 1'b1, 16'h0010, 32'h1234_5678, 1'b0, 32'h0, 4);
    issue(1, 1'b1, 16'h0010, 32'h1234_5678, 1'b0);
    wait_idle();

    // Conflict fairness: both continuously valid, grant order 0,1,0,1
    slave_waits = 0;
    slave_rdata = 32'h0BAD_F00D;
    push(0, 1'b0, 16'h0100, 32'h0,         1'b0, 32'h0BAD_F00D, 1);
    push(1, 1'b1, 16'h0200, 32'h1111_2222, 1'b0, 32'h0,         1);
    push(0, 1'b0, 16'h0104, 32'h0,         1'b0, 32'h0BAD_F00D, 1);
    push(1, 1'b1, 16'h0204, 32'h3333_4444, 1'b0, 32'h0,         1);
    fork
      begin
        issue(0, 1'b0, 16'h0100, 32'h0, 1'b1);
        issue(0, 1'b0, 16'h0104, 32'h0, 1'b0);
      end
      begin
        issue(1, 1'b1, 16'h0200, 32'h1111_2222, 1'b1);
        issue(1, 1'b1, 16'h0204, 32'h3333_4444, 1'b0);
      end
    join
    wait_idle();

    // Timeout on unmapped address with floating pready
    slave_z = 1'b1;
    push(0, 1'b0, 16'h00F0, 32'h0, 1'b1, 32'h0, TO);
    issue(0, 1'b0, 16'h00F0, 32'h0, 1'b0);
    wait_idle();
    slave_z = 1'b0;

    // Reset in the middle of a waited read
    slave_waits = 10;
    push(0, 1'b0, 16'h0300, 32'h0, 1'b0, 32'h0, 11);
    issue(0, 1'b0, 16'h0300, 32'h0, 1'b0);
    repeat (2) @(negedge pclk);
    chk("pre_reset_in_access", {62'd0, psel, penable}, 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_drop", {62'd0, psel, penable}, 64'd0);
    sb.delete();
    repeat (3) begin
      @(negedge pclk);
      chk("no_done_in_reset", {62'd0, req1_done, req0_done}, 64'd0);
    end
    reset = 1'b1;

    // After reset req0 wins the first conflict, then req1 follows
    slave_waits = 0;
    slave_rdata = 32'hCAFE_0001;
    push(0, 1'b0, 16'h0400, 32'h0, 1'b0, 32'hCAFE_0001, 1);
    push(1, 1'b0, 16'h0500, 32'h0, 1'b0, 32'hCAFE_0001, 1);
    fork
      issue(0, 1'b0, 16'h0400, 32'h0, 1'b0);
      issue(1, 1'b0, 16'h0500, 32'h0, 1'b0);
    join
    wait_idle();

    // Withdrawn req1 pulse while req0 is busy
    slave_waits = 5;
    slave_rdata = 32'h5566_7788;
    ack1_seen = 0;
    push(0, 1'b0, 16'h0600, 32'h0, 1'b0, 32'h5566_7788, 6);
    fork
      issue(0, 1'b0, 16'h0600, 32'h0, 1'b0);
      begin
        repeat (3) @(posedge pclk);
        #1;
        req1_write = 1'b1; req1_addr = 16'h0700; req1_wdata = 32'hDEAD_BEEF;
        req1_valid = 1'b1;
        @(negedge pclk);
        if (req1_ack) ack1_seen++;
        @(posedge pclk);
        #1 req1_valid = 1'b0;
      end
    join
    chk("withdrawn_no_ack", 64'(ack1_seen), 64'd0);
    wait_idle();
    repeat (3) @(negedge pclk);
    chk("withdrawn_no_transfer", {62'd0, psel, req1_done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
